rr_arb_mux: RTL and testbench
=============================

Name: rr_arb_mux

Overview:
- Registered, handshaked N-to-1 channel multiplexer with round-robin arbitration and burst locking.
- Successor to the combinational slice mux. Adds valid/ready flow control, an output register stage and multi-beat burst atomicity.
- Optional fixed-select mode reproduces plain indexed muxing.
- Sits between cache-controller request sources (CPU port, writeback buffer, refill engine, snoop) and the single memory-side request channel.

Parameters:
- SEL_WIDTH, 2, bits of channel index; N = 1<<SEL_WIDTH channels.
- W, 32, data width per channel in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N*W  concatenated channel data; channel k at [k*W +: W].
- in_valid  input  N  per-channel valid.
- in_last  input  N  per-channel last-beat-of-burst flag.
- in_ready  output  N  per-channel ready, combinational.
- mode_fixed  input  1  1 = fixed select via sel; 0 = round-robin.
- sel  input  SEL_WIDTH  channel index used when mode_fixed=1.
- out_data  output  W  registered selected data.
- out_ch  output  SEL_WIDTH  registered index of the source channel.
- out_last  output  1  registered last flag.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.
- busy  output  1  high while a burst lock is held.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_ch=0, out_last=0, busy=0, rr pointer ptr=0, lock owner=0.
- can_accept = !out_valid || out_ready. The output register holds its value while out_valid && !out_ready.
- Grant selection, combinational, evaluated each cycle:
  - Locked: grant = lock owner if in_valid[owner], else none. mode_fixed and sel are ignored.
  - Unlocked, mode_fixed=1: grant = sel if in_valid[sel], else none.
  - Unlocked, mode_fixed=0: grant = first k with in_valid[k], scanning ptr, ptr+1, … mod N.
- in_ready[k] = can_accept && grant valid && grant==k. in_ready is one-hot or zero and never depends on in_valid of other channels while locked.
- Transfer on channel k: in_valid[k] && in_ready[k]. On the next edge:
  - out_data = in_data[k*W +: W], out_ch = k, out_last = in_last[k], out_valid = 1.
- No transfer && out_ready: out_valid drops to 0 on the next edge. Data and ch hold their last values.
- Latency 1 cycle input to output. Throughput 1 beat/cycle with out_ready held high.
- Lock:
  - Transfer with in_last=0 sets lock, owner=k, busy=1.
  - Transfer with in_last=1 clears lock, busy=0.
  - A single-beat request (last=1) never locks.
- ptr updates only on a transfer with in_last=1: ptr = (k+1) mod N, natural wrap at N.
  - Fixed-mode transfers update ptr the same way.
- An owner dropping in_valid mid-burst stalls the output. The lock is held indefinitely and other channels stay starved until owner's last beat.
- mode_fixed or sel changing mid-burst has no effect until the lock clears.
- Reset asserted mid-burst: lock, ptr and output clear immediately. The partial burst is discarded and not resumed.
- No X propagation: out_data only changes on a transfer.

Test Plan:
- Reset → out_valid=0, busy=0, in_ready=0000. Then in_valid=1111, all last=1, out_ready=1 for 4 cycles → out_ch sequence 0,1,2,3, then 0 again; one beat per cycle.
- ptr=2 (after grant to ch1), in_valid=1001 → grant ch3, then ch0; ch1/ch2 never ready.
- ch1 sends a 3-beat burst (data 0xA1,0xA2,0xA3; last on third) while ch0/ch2 valid → outputs A1,A2,A3 contiguous with out_ch=1, busy=1 for cycles 1–2; next grant ch2.
- out_ready=0 for 3 cycles with out_valid=1, out_data=0x55 → out_data stable at 0x55, all in_ready=0; out_ready=1 → transfer completes, next beat loads the following cycle.
- mode_fixed=1, sel=2, in_valid=1111 → only ch2 granted each cycle. Switch sel=0 while ch2 burst locked → ch2 finishes its burst before ch0 is granted.
- Assert rst_n=0 during the second beat of a 4-beat burst → outputs, busy and ptr read 0 asynchronously. After release, arbitration restarts at ch0.

Source files
------------

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: registered, handshaked N-to-1 channel multiplexer.
//   Arbitration is round-robin or fixed-select. Multi-beat bursts are kept
//   atomic by locking the grant to the burst owner until its last beat.
//
// Ports (N = 1 << SEL_WIDTH):
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_data    in   N*W concatenated channel data, channel k at [k*W +: W]
//   in_valid   in   N per-channel valid
//   in_last    in   N per-channel last-beat-of-burst flag
//   in_ready   out  N per-channel ready (combinational, one-hot or zero)
//   mode_fixed in   1 = grant channel 'sel', 0 = round-robin
//   sel        in   channel index used in fixed mode
//   out_data   out  registered selected data
//   out_ch     out  registered source channel index
//   out_last   out  registered last flag
//   out_valid  out  registered valid
//   out_ready  in   downstream ready
//   busy       out  high while a burst lock is held
module rr_arb_mux #(
  parameter int SEL_WIDTH = 2,
  parameter int W         = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [(W<<SEL_WIDTH)-1:0]   in_data,
  input  logic [(1<<SEL_WIDTH)-1:0]   in_valid,
  input  logic [(1<<SEL_WIDTH)-1:0]   in_last,
  output logic [(1<<SEL_WIDTH)-1:0]   in_ready,
  input  logic                        mode_fixed,
  input  logic [SEL_WIDTH-1:0]        sel,
  output logic [W-1:0]                out_data,
  output logic [SEL_WIDTH-1:0]        out_ch,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy
);

  localparam int N = 1 << SEL_WIDTH;

  logic [W-1:0]         out_data_q, out_data_d;
  logic [SEL_WIDTH-1:0] out_ch_q, out_ch_d;
  logic                 out_last_q, out_last_d;
  logic                 out_valid_q, out_valid_d;
  logic                 lock_q, lock_d;
  logic [SEL_WIDTH-1:0] owner_q, owner_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;

  logic                 can_accept;
  logic                 grant_valid;
  logic [SEL_WIDTH-1:0] grant_idx;
  logic [SEL_WIDTH-1:0] scan_idx;
  logic                 xfer;
  logic [W-1:0]         ch_data [N];

  assign can_accept = !out_valid_q || out_ready;

  // Grant selection. The round-robin scan walks offsets from the highest
  // down so that the lowest offset from ptr (highest priority) wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    if (lock_q) begin
      grant_idx   = owner_q;
      grant_valid = in_valid[owner_q];
    end else if (mode_fixed) begin
      grant_idx   = sel;
      grant_valid = in_valid[sel];
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        scan_idx = ptr_q + i[SEL_WIDTH-1:0];
        if (in_valid[scan_idx]) begin
          grant_valid = 1'b1;
          grant_idx   = scan_idx;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ch
      assign ch_data[gi]  = in_data[gi*W +: W];
      assign in_ready[gi] = can_accept && grant_valid &&
                            (grant_idx == SEL_WIDTH'(gi));
    end
  endgenerate

  // in_ready of the granted channel equals can_accept, and grant_valid
  // already implies that channel's in_valid.
  assign xfer = grant_valid && can_accept;

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    lock_d      = lock_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = ch_data[grant_idx];
      out_ch_d    = grant_idx;
      out_last_d  = in_last[grant_idx];
      out_valid_d = 1'b1;
      if (in_last[grant_idx]) begin
        // End of burst (or single beat): release lock, advance past winner.
        lock_d = 1'b0;
        ptr_d  = grant_idx + SEL_WIDTH'(1);
      end else begin
        lock_d  = 1'b1;
        owner_d = grant_idx;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      lock_q      <= 1'b0;
      owner_q     <= '0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      lock_q      <= lock_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign busy      = lock_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed testbench for rr_arb_mux (SEL_WIDTH=2, W=32).
// Inputs change on the falling edge; in_ready is sampled 1 ns later and the
// registered outputs are sampled at the following falling edge.
module tb_rr_arb_mux;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_last;
  logic [3:0]   in_ready;
  logic         mode_fixed;
  logic [1:0]   sel;
  logic [31:0]  out_data;
  logic [1:0]   out_ch;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  int tests = 0;
  int fails = 0;

  rr_arb_mux #(.SEL_WIDTH(2), .W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mode_fixed(mode_fixed),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic set_ch(input int k, input logic [31:0] v);
    in_data[k*32 +: 32] = v;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_data = '0; in_valid = '0; in_last = '0;
    mode_fixed = 1'b0; sel = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({out_valid, busy, out_last, out_ch, out_data} !== 37'h0) begin
      fails++;
      $display("FAIL reset_out: got v=%b busy=%b last=%b ch=%0d data=%h, want all 0",
               out_valid, busy, out_last, out_ch, out_data);
    end
    tests++;
    if (in_ready !== 4'b0000) begin
      fails++; $display("FAIL reset_ready: got %b want 0000", in_ready);
    end
    rst_n = 1'b1;
    $display("[TB] reset checked");
  endtask

  // All four channels valid with single beats: grants 0,1,2,3,0.
  task automatic test_rr_all;
    logic [3:0] exp_rdy;
    logic [1:0] exp_ch;
    for (int k = 0; k < 4; k++) set_ch(k, 32'h100 + k);
    in_last = 4'b1111; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_ch  = 2'(i % 4);
      exp_rdy = 4'b0001 << exp_ch;
      #1;
      tests++;
      if (in_ready !== exp_rdy) begin
        fails++; $display("FAIL rr_ready[%0d]: got %b want %b", i, in_ready, exp_rdy);
      end
      @(negedge clk);
      tests++;
      if ({out_valid, out_ch, out_last, out_data} !== {1'b1, exp_ch, 1'b1, 32'h100 + 32'(exp_ch)}) begin
        fails++;
        $display("FAIL rr_out[%0d]: got v=%b ch=%0d last=%b data=%h want v=1 ch=%0d last=1 data=%h",
                 i, out_valid, out_ch, out_last, out_data, exp_ch, 32'h100 + 32'(exp_ch));
      end
      $display("[TB] rr beat %0d ch=%0d data=%h", i, out_ch, out_data);
    end
    in_valid = 4'b0000;
    @(negedge clk);
    tests++;
    if ({out_valid, out_ch, out_data} !== {1'b0, 2'd0, 32'h100}) begin
      fails++;
      $display("FAIL rr_idle: got v=%b ch=%0d data=%h want v=0 ch=0 data=00000100",
               out_valid, out_ch, out_data);
    end
  endtask

  // ptr=1 on entry; grant ch1 -> ptr=2; then 1001 yields ch3 then ch0.
  task automatic test_skip;
    set_ch(1, 32'h11); set_ch(3, 32'h33); set_ch(0, 32'h30);
    in_last = 4'b1111; in_valid = 4'b0010;
    @(negedge clk);
    in_valid = 4'b1001;
    #1;
    tests++;
    if (in_ready !== 4'b1000) begin
      fails++; $display("FAIL skip_ready3: got %b want 1000", in_ready);
    end
    @(negedge clk);
    tests++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd3, 32'h33}) begin
      fails++; $display("FAIL skip_out3: got v=%b ch=%0d data=%h want v=1 ch=3 data=00000033",
                        out_valid, out_ch, out_data);
    end
    #1;
    tests++;
    if (in_ready !== 4'b0001) begin
      fails++; $display("FAIL skip_ready0: got %b want 0001", in_ready);
    end
    @(negedge clk);
    tests++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, 32'h30}) begin
      fails++; $display("FAIL skip_out0: got v=%b ch=%0d data=%h want v=1 ch=0 data=00000030",
                        out_valid, out_ch, out_data);
    end
    $display("[TB] skip done ch=%0d", out_ch);
    in_valid = 4'b0000;
    @(negedge clk);
  endtask

  // ptr=1 on entry; ch1 3-beat burst with ch0/ch2 also valid, then ch2.
  task automatic test_burst;
    logic [31:0] beat_data [3];
    beat_data[0] = 32'hA1; beat_data[1] = 32'hA2; beat_data[2] = 32'hA3;
    set_ch(0, 32'hC0); set_ch(2, 32'hC2);
    in_valid = 4'b0111;
    for (int b = 0; b < 3; b++) begin
      set_ch(1, beat_data[b]);
      in_last = (b == 2) ? 4'b0111 : 4'b0101;
      #1;
      tests++;
      if (in_ready !== 4'b0010) begin
        fails++; $display("FAIL burst_ready[%0d]: got %b want 0010", b, in_ready);
      end
      @(negedge clk);
      tests++;
      if ({out_valid, out_ch, out_last, busy, out_data} !==
          {1'b1, 2'd1, (b == 2), (b != 2), beat_data[b]}) begin
        fails++;
        $display("FAIL burst_out[%0d]: got v=%b ch=%0d last=%b busy=%b data=%h want v=1 ch=1 last=%b busy=%b data=%h",
                 b, out_valid, out_ch, out_last, busy, out_data, (b == 2), (b != 2), beat_data[b]);
      end
      $display("[TB] burst beat %0d data=%h busy=%b", b, out_data, busy);
    end
    in_valid = 4'b0101;
    #1;
    tests++;
    if (in_ready !== 4'b0100) begin
      fails++; $display("FAIL burst_next_ready: got %b want 0100", in_ready);
    end
    @(negedge clk);
    tests++;
    if ({out_ch, out_data} !== {2'd2, 32'hC2}) begin
      fails++; $display("FAIL burst_next_out: got ch=%0d data=%h want ch=2 data=000000c2", out_ch, out_data);
    end
    in_valid = 4'b0000;
    @(negedge clk);
  endtask

  // ptr=3 on entry; load 0x55 from ch3, then stall 3 cycles.
  task automatic test_backpressure;
    set_ch(3, 32'h55); set_ch(0, 32'h66);
    in_last = 4'b1111; in_valid = 4'b1000;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (in_ready !== 4'b0000) begin
        fails++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, in_ready);
      end
      @(negedge clk);
      tests++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 2'd3, 32'h55}) begin
        fails++; $display("FAIL bp_hold[%0d]: got v=%b ch=%0d data=%h want v=1 ch=3 data=00000055",
                          c, out_valid, out_ch, out_data);
      end
      $display("[TB] stall cycle %0d data=%h", c, out_data);
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 4'b0001) begin
      fails++; $display("FAIL bp_release_ready: got %b want 0001", in_ready);
    end
    @(negedge clk);
    tests++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, 32'h66}) begin
      fails++; $display("FAIL bp_release_out: got v=%b ch=%0d data=%h want v=1 ch=0 data=00000066",
                        out_valid, out_ch, out_data);
    end
    in_valid = 4'b0000;
    @(negedge clk);
  endtask

  // Fixed sel=2; ch2 burst locks; sel switched to 0 and owner stall mid-burst.
  task automatic test_fixed;
    for (int k = 0; k < 4; k++) set_ch(k, 32'hF0 + k);
    mode_fixed = 1'b1; sel = 2'd2; in_valid = 4'b1111; in_last = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      #1;
      tests++;
      if (in_ready !== 4'b0100) begin
        fails++; $display("FAIL fixed_ready[%0d]: got %b want 0100", c, in_ready);
      end
      @(negedge clk);
      tests++;
      if ({out_ch, out_data} !== {2'd2, 32'hF2}) begin
        fails++; $display("FAIL fixed_out[%0d]: got ch=%0d data=%h want ch=2 data=000000f2", c, out_ch, out_data);
      end
    end
    set_ch(2, 32'hB1); in_last = 4'b1011;
    @(negedge clk);
    sel = 2'd0; set_ch(2, 32'hB2);
    #1;
    tests++;
    if (in_ready !== 4'b0100) begin
      fails++; $display("FAIL fixed_lock_ready: got %b want 0100", in_ready);
    end
    @(negedge clk);
    tests++;
    if ({busy, out_ch, out_data} !== {1'b1, 2'd2, 32'hB2}) begin
      fails++; $display("FAIL fixed_lock_out: got busy=%b ch=%0d data=%h want busy=1 ch=2 data=000000b2",
                        busy, out_ch, out_data);
    end
    in_valid = 4'b1011;
    #1;
    tests++;
    if (in_ready !== 4'b0000) begin
      fails++; $display("FAIL fixed_starve_ready: got %b want 0000", in_ready);
    end
    @(negedge clk);
    tests++;
    if ({out_valid, busy} !== 2'b01) begin
      fails++; $display("FAIL fixed_starve_out: got v=%b busy=%b want v=0 busy=1", out_valid, busy);
    end
    in_valid = 4'b1111; set_ch(2, 32'hB3); in_last = 4'b1111;
    @(negedge clk);
    tests++;
    if ({out_valid, busy, out_last, out_ch, out_data} !== {1'b1, 1'b0, 1'b1, 2'd2, 32'hB3}) begin
      fails++; $display("FAIL fixed_burst_end: got v=%b busy=%b last=%b ch=%0d data=%h want v=1 busy=0 last=1 ch=2 data=000000b3",
                        out_valid, busy, out_last, out_ch, out_data);
    end
    #1;
    tests++;
    if (in_ready !== 4'b0001) begin
      fails++; $display("FAIL fixed_sel0_ready: got %b want 0001", in_ready);
    end
    @(negedge clk);
    tests++;
    if ({out_ch, out_data} !== {2'd0, 32'hF0}) begin
      fails++; $display("FAIL fixed_sel0_out: got ch=%0d data=%h want ch=0 data=000000f0", out_ch, out_data);
    end
    $display("[TB] fixed mode done ch=%0d", out_ch);
    mode_fixed = 1'b0; in_valid = 4'b0000;
    @(negedge clk);
  endtask

  // ch2 starts a 4-beat burst; reset during beat 2; arbitration restarts at ch0.
  task automatic test_reset_mid_burst;
    set_ch(2, 32'hD1); in_last = 4'b0000; in_valid = 4'b0100;
    @(negedge clk);
    tests++;
    if ({busy, out_ch, out_data} !== {1'b1, 2'd2, 32'hD1}) begin
      fails++; $display("FAIL rstmid_beat1: got busy=%b ch=%0d data=%h want busy=1 ch=2 data=000000d1",
                        busy, out_ch, out_data);
    end
    set_ch(2, 32'hD2);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, busy, out_last, out_ch, out_data} !== 37'h0) begin
      fails++; $display("FAIL rstmid_async: got v=%b busy=%b last=%b ch=%0d data=%h want all 0",
                        out_valid, busy, out_last, out_ch, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) set_ch(k, 32'hE0 + k);
    in_valid = 4'b1111; in_last = 4'b1111;
    #1;
    tests++;
    if (in_ready !== 4'b0001) begin
      fails++; $display("FAIL rstmid_restart_ready: got %b want 0001", in_ready);
    end
    @(negedge clk);
    tests++;
    if ({out_valid, busy, out_ch, out_data} !== {1'b1, 1'b0, 2'd0, 32'hE0}) begin
      fails++; $display("FAIL rstmid_restart_out: got v=%b busy=%b ch=%0d data=%h want v=1 busy=0 ch=0 data=000000e0",
                        out_valid, busy, out_ch, out_data);
    end
    #1;
    tests++;
    if (in_ready !== 4'b0010) begin
      fails++; $display("FAIL rstmid_next_ready: got %b want 0010", in_ready);
    end
    $display("[TB] reset mid-burst done");
    in_valid = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_rr_all;
    test_skip;
    test_burst;
    test_backpressure;
    test_fixed;
    test_reset_mid_burst;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
